// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch stage, the instruction memory port and decode.
// The fetch stage uses the master modport; memory/decode/redirect logic uses slave.
interface instruction_fetch_if #(
    parameter int PERF_WIDTH = 32
);
    logic [31:0]           imem_address;
    logic                  imem_enable;
    logic [31:0]           imem_data;
    logic                  imem_wait;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_pc;
    logic [31:0]           out_instr;
    logic                  out_misaligned;
    logic [PERF_WIDTH-1:0] perf_fetched;
    logic [PERF_WIDTH-1:0] perf_stalls;

    modport master (
        output imem_address, imem_enable,
        input  imem_data, imem_wait,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_instr, out_misaligned,
        input  out_ready,
        output perf_fetched, perf_stalls
    );

    modport slave (
        input  imem_address, imem_enable,
        output imem_data, imem_wait,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_instr, out_misaligned,
        output out_ready,
        input  perf_fetched, perf_stalls
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: issues PCs to a 1-cycle synchronous ROM and buffers responses in a 2-entry FIFO.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          PERF_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    instruction_fetch_if.master bus
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        resp_pending_q, resp_pending_d;
    logic [31:0] buf_pc_q[2], buf_pc_d[2];
    logic [31:0] buf_instr_q[2], buf_instr_d[2];
    logic        head_q, head_d;
    logic [1:0]  count_q, count_d;

    logic        out_valid;
    logic        pop;
    logic        push;
    logic        issue;
    logic        tail;
    logic [2:0]  occ;
    logic [31:0] fetch_addr;
    logic        fetch_en;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        out_valid = (count_q != 2'd0) && !bus.redirect_valid;
        pop       = out_valid && bus.out_ready;
        occ       = {1'b0, count_q} + {2'b00, resp_pending_q};
        // Credits count both buffered entries and the response still in flight.
        fetch_en  = !reset && (bus.redirect_valid || ((occ - {2'b00, pop}) < 3'd2));
        if (reset)
            fetch_addr = RESET_PC;
        else if (bus.redirect_valid)
            fetch_addr = bus.redirect_pc;
        else
            fetch_addr = pc_q;
        issue = fetch_en && !bus.imem_wait;
        push  = resp_pending_q && !bus.redirect_valid;
        tail  = head_q ^ count_q[0];

        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        resp_pending_d = issue;
        buf_pc_d       = buf_pc_q;
        buf_instr_d    = buf_instr_q;
        head_d         = head_q;
        count_d        = count_q;

        if (issue) begin
            pc_d     = fetch_addr + 32'd4;
            req_pc_d = fetch_addr;
        end else if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end

        if (bus.redirect_valid) begin
            head_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                buf_pc_d[tail]    = req_pc_q;
                buf_instr_d[tail] = bus.imem_data;
            end
            head_d  = head_q ^ pop;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: the two buffer entries are reset so out_pc/out_instr read zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            req_pc_q       <= RESET_PC;
            resp_pending_q <= 1'b0;
            buf_pc_q[0]    <= 32'd0;
            buf_pc_q[1]    <= 32'd0;
            buf_instr_q[0] <= 32'd0;
            buf_instr_q[1] <= 32'd0;
            head_q         <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            pc_q           <= pc_d;
            req_pc_q       <= req_pc_d;
            resp_pending_q <= resp_pending_d;
            buf_pc_q       <= buf_pc_d;
            buf_instr_q    <= buf_instr_d;
            head_q         <= head_d;
            count_q        <= count_d;
        end
    end

    assign bus.imem_address   = fetch_addr;
    assign bus.imem_enable    = fetch_en;
    assign bus.out_valid      = out_valid;
    assign bus.out_pc         = buf_pc_q[head_q];
    assign bus.out_instr      = buf_instr_q[head_q];
    assign bus.out_misaligned = (buf_pc_q[head_q][1:0] != 2'b00);

`ifdef IFETCH_PERF_EN
    logic [PERF_WIDTH-1:0] perf_fetched_q, perf_fetched_d;
    logic [PERF_WIDTH-1:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + PERF_WIDTH'(pop);
        perf_stalls_d  = perf_stalls_q + PERF_WIDTH'(out_valid && !bus.out_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stalls_q  <= perf_stalls_d;
        end
    end

    assign bus.perf_fetched = perf_fetched_q;
    assign bus.perf_stalls  = perf_stalls_q;
`else
    assign bus.perf_fetched = {PERF_WIDTH{1'b0}};
    assign bus.perf_stalls  = {PERF_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized phase,
// checked against a queue of issued fetches that mature two cycles after issue.
module tb_instruction_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        int          t;
    } flight_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    instruction_fetch_if #(.PERF_WIDTH(32)) bus ();

    instruction_fetch #(.RESET_PC(RESET_PC), .PERF_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    flight_t     q[$];
    logic [31:0] fetch_pc = RESET_PC;
    int          cyc = 0;
    int          n_fetched = 0;
    int          n_stalls = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Synchronous ROM: answers an accepted request one cycle later, junk otherwise.
    always @(posedge clk) begin
        if (bus.imem_enable && !bus.imem_wait)
            bus.imem_data <= rom(bus.imem_address);
        else
            bus.imem_data <= $urandom;
    end

    function automatic logic [31:0] perf_exp(input int n);
`ifdef IFETCH_PERF_EN
        return 32'(n);
`else
        return 32'(0) & 32'(n);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives one cycle of inputs, checks, advances the model.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic wt, input logic rdy);
        logic        exp_valid;
        logic        exp_pop;
        logic        exp_en;
        logic        exp_issue;
        logic [31:0] exp_addr;
        int          remaining;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.imem_wait      = wt;
        bus.out_ready      = rdy;
        #1;
        exp_valid = !rv && (q.size() > 0) && (cyc >= q[0].t + 2);
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_pc", bus.out_pc, q[0].pc);
            check("out_instr", bus.out_instr, rom(q[0].pc));
            check("out_misaligned", 32'(bus.out_misaligned), 32'(q[0].pc[1:0] != 2'b00));
        end
        exp_pop   = exp_valid && rdy;
        remaining = q.size() - (exp_pop ? 1 : 0);
        exp_en    = rv || (remaining < 2);
        exp_addr  = rv ? rpc : fetch_pc;
        exp_issue = exp_en && !wt;
        check("imem_enable", 32'(bus.imem_enable), 32'(exp_en));
        check("imem_address", bus.imem_address, exp_addr);
        check("perf_fetched", bus.perf_fetched, perf_exp(n_fetched));
        check("perf_stalls", bus.perf_stalls, perf_exp(n_stalls));

        if (rv) q.delete();
        else if (exp_pop) void'(q.pop_front());
        if (exp_issue) q.push_back('{pc: exp_addr, t: cyc});
        if (exp_issue) fetch_pc = exp_addr + 32'd4;
        else if (rv) fetch_pc = rpc;
        if (exp_pop) n_fetched++;
        if (exp_valid && !rdy) n_stalls++;
        cyc++;
        @(negedge clk);
    endtask

    // Asserts reset immediately (possibly mid-cycle) and releases it on a negedge.
    task automatic apply_reset(input int n);
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.imem_wait      = 1'b0;
        bus.out_ready      = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_imem_enable", 32'(bus.imem_enable), 32'd0);
        check("rst_imem_address", bus.imem_address, RESET_PC);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_misaligned", 32'(bus.out_misaligned), 32'd0);
        check("rst_perf_fetched", bus.perf_fetched, 32'd0);
        check("rst_perf_stalls", bus.perf_stalls, 32'd0);
        repeat (n) @(negedge clk);
        reset     = 1'b0;
        q.delete();
        fetch_pc  = RESET_PC;
        cyc       = 0;
        n_fetched = 0;
        n_stalls  = 0;
    endtask

    initial begin
        logic        rv;
        logic        wt;
        logic        rdy;
        logic [31:0] rpc;

        @(negedge clk);
        apply_reset(3);

        // Sequential stream from RESET_PC, first valid two cycles after release.
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("t1_first_valid", 32'(bus.out_valid), 32'd1);
        check("t1_first_pc", bus.out_pc, 32'h0);
        check("t1_first_instr", bus.out_instr, rom(32'h0));
        repeat (4) step(1'b0, 32'd0, 1'b0, 1'b1);

        // Decode stall: credits run out, nothing lost or repeated on resume.
        repeat (5) step(1'b0, 32'd0, 1'b0, 1'b0);
        check("t2_enable_dropped", 32'(bus.imem_enable), 32'd0);
        check("t2_hold_valid", 32'(bus.out_valid), 32'd1);

        // Redirect while two entries are buffered.
        step(1'b1, 32'h40, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("t3_redirect_valid", 32'(bus.out_valid), 32'd1);
        check("t3_redirect_pc", bus.out_pc, 32'h40);
        repeat (3) step(1'b0, 32'd0, 1'b0, 1'b1);

        // Memory wait at pc 0x10.
        step(1'b1, 32'h10, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t4_wait_address", bus.imem_address, 32'h10);
        check("t4_wait_no_valid", 32'(bus.out_valid), 32'd0);
        repeat (4) step(1'b0, 32'd0, 1'b0, 1'b1);

        // Misaligned redirect target.
        step(1'b1, 32'h22, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("t5_mis_pc", bus.out_pc, 32'h22);
        check("t5_mis_flag", 32'(bus.out_misaligned), 32'd1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check("t5_next_pc", bus.out_pc, 32'h26);
        repeat (2) step(1'b0, 32'd0, 1'b0, 1'b1);

        // Address wrap past 0xFFFF_FFFC.
        step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        repeat (5) step(1'b0, 32'd0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 19) == 0);
            wt  = ($urandom_range(0, 4) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rpc = $urandom & 32'h0000_03FC;
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(rv, rpc, wt, rdy);
        end

        // Reset asserted in the middle of a cycle while busy.
        #3;
        apply_reset(2);
        repeat (6) step(1'b0, 32'd0, 1'b0, 1'b1);

        // Performance counters: 4 stall cycles then 10 pops.
        apply_reset(2);
        repeat (2) step(1'b0, 32'd0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 32'd0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 32'd0, 1'b0, 1'b1);
`ifdef IFETCH_PERF_EN
        check("t6_perf_fetched", bus.perf_fetched, 32'd10);
        check("t6_perf_stalls", bus.perf_stalls, 32'd4);
`else
        check("t6_perf_fetched", bus.perf_fetched, 32'd0);
        check("t6_perf_stalls", bus.perf_stalls, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
